// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its decoder.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    // LSB position of field idx inside a packed multi-port bus of w-bit fields
    function automatic int port_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard; a reservation beats a write to the same entry.
module regfile_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_set_en,
    input  logic [AW-1:0]    i_set_addr,
    input  logic             i_clr_en,
    input  logic [AW-1:0]    i_clr_addr,
    output logic [DEPTH-1:0] o_pending
);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;

    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) w_pending_nxt[i_clr_addr] = 1'b0;
        if (i_set_en) w_pending_nxt[i_set_addr] = 1'b1;
        if (i_flush)  w_pending_nxt = '0;
        if (ZERO_REG) w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_pending <= '0;
        else         r_pending <= w_pending_nxt;
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, optional zero entry, scoreboard and clear walker.
//   state    | meaning
//   ST_CLEAR | walker zeroes one entry per cycle; requests ignored, reads return 0
//   ST_READY | normal operation; clear_req restarts the walk
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic [DEPTH-1:0]         pending,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic [AW-1:0]            dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_ready;
    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_flush;

    assign w_ready  = (r_state == ST_READY);
    assign w_flush  = w_ready && clear_req;
    assign w_wr_ok  = w_ready && wr_en && !clear_req && !(ZERO_REG && (wr_addr == '0));
    assign w_rsv_ok = w_ready && rsv_en && !clear_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_CLEAR;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == AW'(DEPTH - 1)) w_state_nxt = ST_READY;
            ST_READY: if (clear_req)                   w_state_nxt = ST_CLEAR;
            default:                                   w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_CLEAR);
    end

    // Counter wraps to 0 on the last walk edge, so READY always starts at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   r_clr_cnt <= '0;
        else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + AW'(1);
        else if (clear_req)           r_clr_cnt <= '0;
    end

    always_ff @(posedge clock) begin
        if (r_state == ST_CLEAR) r_mem[r_clr_cnt] <= '0;
        else if (w_wr_ok)        r_mem[wr_addr]   <= wr_data;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[port_lsb(g, AW) +: AW];

        always_comb begin
            w_data = r_mem[w_addr];
            if (BYPASS && w_ready && wr_en && (wr_addr == w_addr)) w_data = wr_data;
            if (ZERO_REG && (w_addr == '0))                        w_data = '0;
            if (!w_ready)                                          w_data = '0;
        end

        assign rd_data[port_lsb(g, DATA_W) +: DATA_W] = w_data;
    end

    assign dbg_data = w_ready ? r_mem[dbg_addr] : '0;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_flush    (w_flush),
        .i_set_en   (w_rsv_ok),
        .i_set_addr (rsv_addr),
        .i_clr_en   (w_wr_ok),
        .i_clr_addr (wr_addr),
        .o_pending  (pending)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with an abstract reference model and per-cycle compare.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [D-1:0]     pending;
    logic             clear_req;
    logic             busy;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_data;

    regfile_mp #(
        .DATA_W   (DW),
        .DEPTH    (D),
        .NUM_RD   (NR),
        .BYPASS   (1'b1),
        .ZERO_REG (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .pending   (pending),
        .clear_req (clear_req),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents, which entries hold a known value, pending set, cycles of clearing left
    logic [DW-1:0] m_mem [D];
    bit            m_known [D];
    logic [D-1:0]  m_pend = '0;
    int            m_clear_left = D;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_clear_left = D;
            m_pend       = '0;
        end else if (m_clear_left > 0) begin
            m_mem[D - m_clear_left]   = '0;
            m_known[D - m_clear_left] = 1'b1;
            m_clear_left--;
        end else if (clear_req) begin
            m_clear_left = D;
            m_pend       = '0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]   = wr_data;
                m_known[wr_addr] = 1'b1;
                m_pend[wr_addr]  = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (check_en && !reset) begin
            check("busy", busy, m_clear_left > 0);
            check("pending", pending, m_pend);
            for (int p = 0; p < NR; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                if (m_clear_left > 0 || a == 0)
                    check("rd_data", rd_data[p*DW +: DW], '0);
                else if (wr_en && int'(wr_addr) == a)
                    check("rd_bypass", rd_data[p*DW +: DW], wr_data);
                else if (m_known[a])
                    check("rd_data", rd_data[p*DW +: DW], m_mem[a]);
            end
            if (m_clear_left > 0)
                check("dbg_data", dbg_data, '0);
            else if (m_known[dbg_addr])
                check("dbg_data", dbg_data, m_mem[dbg_addr]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rsv_en    = 1'b0;
        clear_req = 1'b0;
    endtask

    // Called on a negedge; counts consecutive negedges with busy high (bounded)
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < D; i++) begin
            dbg_addr = AW'(i);
            rd_addr  = {AW'(i), AW'(i)};
            @(negedge clock);
            check(name, dbg_data, 32'h0);
            check(name, rd_data[DW-1:0], 32'h0);
            step();
        end
    endtask

    initial begin
        int n;
        idle();
        rd_addr  = '0;
        dbg_addr = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_en = 1'b1;
        @(negedge clock);
        count_busy(n);
        check("init_busy_len", n, 32);

        // Fill with garbage, then reset: the walker must wipe it
        for (int i = 0; i < D; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = $urandom | 32'h1;
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        count_busy(n);
        check("reset_busy_len", n, 32);
        sweep_zero("reset_clear");

        // Write then read on both ports and debug
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        idle();
        rd_addr = {5'd5, 5'd5}; dbg_addr = 5'd5;
        @(negedge clock);
        check("rd0_reg5", rd_data[31:0], 32'hDEADBEEF);
        check("rd1_reg5", rd_data[63:32], 32'hDEADBEEF);
        check("dbg_reg5", dbg_data, 32'hDEADBEEF);
        step();

        // Same-cycle bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr = {5'd5, 5'd7};
        @(negedge clock);
        check("bypass_rd0", rd_data[31:0], 32'h12345678);
        check("bypass_rd1_other", rd_data[63:32], 32'hDEADBEEF);
        step();

        // Zero register ignores writes and reservations
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        @(negedge clock);
        check("zero_bypass", rd_data[31:0], 32'h0);
        step();
        idle(); dbg_addr = 5'd0;
        @(negedge clock);
        check("zero_rd", rd_data[31:0], 32'h0);
        check("zero_pend", pending[0], 1'b0);
        check("zero_dbg", dbg_data, 32'h0);
        step();

        // Scoreboard priority
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        check("pend3_set", pending[3], 1'b1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        step();
        check("pend3_set_wins", pending[3], 1'b1);
        idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        step();
        check("pend3_cleared", pending[3], 1'b0);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
        step();
        rsv_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        idle();
        check("pend4_set", pending[4], 1'b1);
        check("pend9_clr", pending[9], 1'b0);

        // Re-clear with a simultaneous write that must be dropped
        rsv_en = 1'b1; rsv_addr = 5'd6;
        step();
        idle();
        check("pend6_set", pending[6], 1'b1);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h0BADF00D;
        step();
        wr_data = 32'h55555555; clear_req = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd8;
        @(negedge clock);
        check("busy_before_edge", busy, 1'b0);
        step();
        idle();
        @(negedge clock);
        check("reclear_busy", busy, 1'b1);
        check("reclear_pend", pending, 32'h0);
        count_busy(n);
        check("reclear_busy_len", n, 32);
        check("reclear_pend_after", pending, 32'h0);
        sweep_zero("reclear_zero");

        // Reset in the middle of a walk restarts it from the beginning
        clear_req = 1'b1;
        step();
        idle();
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        count_busy(n);
        check("midclear_busy_len", n, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
